regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, multi-cycle units) using valid/ready handshakes, and registers the winning write one cycle before it reaches the 16×32 register file. It also keeps a pending-write scoreboard that the issue stage queries for RAW/WAW hazards. It sits between the execute/writeback units and the register file's `write`/`rd`/`writeData` inputs.

## Interface
- `NUM_REQ`, 3, number of writeback requesters (2..4).
- `DATA_W`, 32, write data width.
- `ADDR_W`, 4, register index width.
- `ZERO_REG`, 14, index of the hardwired-zero register.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wb_valid`  in  NUM_REQ  requester i has a write pending.
- `wb_rd`  in  NUM_REQ*ADDR_W  destination index of requester i, at bits `[i*ADDR_W +: ADDR_W]`.
- `wb_data`  in  NUM_REQ*DATA_W  write data of requester i, at bits `[i*DATA_W +: DATA_W]`.
- `wb_ready`  out  NUM_REQ  one-hot grant, combinational from `wb_valid` and arbiter state.
- `iss_valid`  in  1  issue stage is issuing an instruction.
- `iss_rd`, `iss_rs1`, `iss_rs2`  in  ADDR_W each  destination and sources of the issuing instruction.
- `iss_hazard`  out  1  combinational: `iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd])`.
- `pending`  out  16  scoreboard vector; bit r = write to Rr outstanding.
- `rf_write`, `rf_rd`, `rf_wdata`  out  1/ADDR_W/DATA_W  registered register-file write port.

## Operation
- Transfer on requester i: `wb_valid[i] & wb_ready[i]`. At most one `wb_ready` bit is high per cycle, and only toward a valid requester. `wb_ready` is all-zero when no `wb_valid` bit is set.
- A requester holds `wb_valid`, `wb_rd`, and `wb_data` stable until its transfer.
- On a transfer, the output stage loads `rf_rd`/`rf_wdata` from the winner. `rf_write` is set to 1 unless `wb_rd == ZERO_REG`. A ZERO_REG write is accepted and discarded with `rf_write = 0`.
- With no transfer, `rf_write` is 0 next cycle, and `rf_rd`/`rf_wdata` hold their values.
- Scoreboard set: `iss_valid & !iss_hazard & iss_rd != ZERO_REG` sets `pending[iss_rd]` at the clock edge.
- Scoreboard clear: a cycle with `rf_write = 1` clears `pending[rf_rd]` at the same edge the register file captures the data.
- Set and clear of the same index at the same edge: set wins.
- `pending[ZERO_REG]` is constant 0.
- A writeback to a register with no pending bit is still written; the scoreboard is unaffected.

## Timing
- Latency: transfer in cycle N gives `rf_write`/`rf_rd`/`rf_wdata` valid in cycle N+1. The register file holds the value from edge N+2, and `pending` drops from cycle N+2.
- Throughput: one write per cycle, sustained.
- Reset values:
  - `rf_write = 0`, `rf_rd = 0`, `rf_wdata = 0`, `pending = 0`.
  - `wb_ready = 0` while `rst` is high.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight output-stage write is dropped (`rf_write = 0` in the cycle after the `rst` edge). All pending bits clear. Requesters must re-present their writes.
- Simultaneous issue claim and writeback of the same rd in one cycle: the claim sets `pending`, per the set-wins rule above.

## Configuration
- `WB_RR_ARB_EN` defined:
  - Round-robin arbitration. The search starts at (last granted index + 1) mod NUM_REQ.
  - The pointer updates only on a transfer.
  - Any continuously valid requester is granted within NUM_REQ cycles.
- `WB_RR_ARB_EN` undefined:
  - Fixed priority; the lowest index wins.
  - No pointer register exists.
  - Starvation of high-index requesters is permitted.

## Test plan
- Reset, then requester 0 writes rd=3, data 0xDEADBEEF in cycle 1: `wb_ready = 001` in cycle 1. Cycle 2 shows `rf_write = 1`, `rf_rd = 3`, `rf_wdata = 0xDEADBEEF`. After the cycle-2 edge the register file reads R3 = 0xDEADBEEF.
- All three requesters valid for 6 cycles (rd 1/2/3) with `WB_RR_ARB_EN`: grant order 0,1,2,0,1,2. Without the macro: grant 0 every cycle.
- Requester 1 writes rd=14, data 5: `wb_ready[1] = 1` and the transfer completes. Next cycle `rf_write = 0` and `pending[14]` stays 0.
- Issue rd=7 (no hazard): `pending[7] = 1` next cycle. Issue with rs1=7: `iss_hazard = 1` and no scoreboard set. Writeback rd=7: `pending[7]` is 0 two cycles after the transfer.
- Issue rd=5 in the same cycle that `rf_write = 1`, `rf_rd = 5`: `pending[5]` remains 1 afterward.
- Transfer in cycle N with `rst` asserted in cycle N+1: `rf_write = 0` in cycle N+2, `pending = 0`, and the target register is unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a registered write port and a pending-write scoreboard.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise the lowest valid index wins.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        wb_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] wb_rd,
  input  logic [NUM_REQ*DATA_W-1:0] wb_data,
  output logic [NUM_REQ-1:0]        wb_ready,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  input  logic [ADDR_W-1:0]         iss_rs1,
  input  logic [ADDR_W-1:0]         iss_rs2,
  output logic                      iss_hazard,
  output logic [(1<<ADDR_W)-1:0]    pending,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_wdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZREG = ADDR_W'(ZERO_REG);

  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_any;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_win_rd;
  logic [DATA_W-1:0] w_win_data;
  logic              w_set;
  logic [NREG-1:0]   w_pend_nxt;

  logic              r_wr_vld_p1;
  logic [ADDR_W-1:0] r_rd_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic [NREG-1:0]   r_pending;

  // ---- stage p0: arbitration ----
`ifdef WB_RR_ARB_EN
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_cand;

  // Search begins one past the last winner so every valid requester is served within NUM_REQ grants.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_gnt_any && wb_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_last <= IDX_W'(NUM_REQ - 1);
    else if (w_xfer) r_last <= w_gnt_idx;
  end
`else
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (wb_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    wb_ready = '0;
    if (w_gnt_any && !rst) wb_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer     = w_gnt_any & ~rst;
  assign w_win_rd   = wb_rd[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_win_data = wb_data[w_gnt_idx*DATA_W +: DATA_W];

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_vld_p1 <= 1'b0;
      r_rd_p1     <= '0;
      r_wdata_p1  <= '0;
    end else begin
      r_wr_vld_p1 <= w_xfer && (w_win_rd != ZREG);
      if (w_xfer) begin
        r_rd_p1    <= w_win_rd;
        r_wdata_p1 <= w_win_data;
      end
    end
  end

  // Masking with rst drops the in-flight write so a reset never lands a stale value in the file.
  assign rf_write = r_wr_vld_p1 & ~rst;
  assign rf_rd    = r_rd_p1;
  assign rf_wdata = r_wdata_p1;

  // ---- scoreboard ----
  assign iss_hazard = iss_valid & (r_pending[iss_rs1] | r_pending[iss_rs2] | r_pending[iss_rd]);
  assign w_set      = iss_valid & ~iss_hazard & (iss_rd != ZREG);

  // Clear first, then set, so a claim in the same cycle as the retiring write survives.
  always_comb begin
    w_pend_nxt = r_pending;
    if (rf_write) w_pend_nxt[rf_rd] = 1'b0;
    if (w_set)    w_pend_nxt[iss_rd] = 1'b1;
    w_pend_nxt[ZREG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pend_nxt;
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic against
// a cycle-level behavioural model (arbitration order, write port, scoreboard, register file).
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int ZR = 14;
  localparam int NR = 16;

  logic              clk;
  logic              rst;
  logic [N-1:0]      wb_valid;
  logic [N*AW-1:0]   wb_rd;
  logic [N*DW-1:0]   wb_data;
  logic [N-1:0]      wb_ready;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd, iss_rs1, iss_rs2;
  logic              iss_hazard;
  logic [NR-1:0]     pending;
  logic              rf_write;
  logic [AW-1:0]     rf_rd;
  logic [DW-1:0]     rf_wdata;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ready(wb_ready), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_hazard(iss_hazard), .pending(pending), .rf_write(rf_write),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen through the DUT's write port.
  logic [DW-1:0] dut_rf [NR];
  always @(posedge clk) if (rf_write) dut_rf[rf_rd] <= rf_wdata;

  // Requester and model state
  logic          req_v [N];
  logic [AW-1:0] req_rd [N];
  logic [DW-1:0] req_data [N];
  logic          m_pend [NR];
  logic [DW-1:0] m_rf [NR];
  logic          m_wr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wdata;
  int            m_last;

  logic [N-1:0]  s_ready;
  logic          s_haz, s_rfw;
  logic [AW-1:0] s_rd;
  logic [DW-1:0] s_wdata;
  logic [NR-1:0] s_pend;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, advance the model at the edge.
  task automatic step();
    int g;
    logic haz;
    logic [N-1:0] e_ready;
    logic [NR-1:0] e_pend;
    for (int i = 0; i < N; i++) begin
      wb_valid[i]            = req_v[i];
      wb_rd[i*AW +: AW]      = req_rd[i];
      wb_data[i*DW +: DW]    = req_data[i];
    end
    @(negedge clk);
    g = -1;
    if (!rst) begin
`ifdef WB_RR_ARB_EN
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_v[(m_last + k) % N]) g = (m_last + k) % N;
`else
      for (int i = 0; i < N; i++)
        if (g < 0 && req_v[i]) g = i;
`endif
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    haz = iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
    for (int r = 0; r < NR; r++) e_pend[r] = m_pend[r];

    s_ready = wb_ready; s_haz = iss_hazard; s_rfw = rf_write;
    s_rd = rf_rd; s_wdata = rf_wdata; s_pend = pending;
    check("wb_ready", s_ready, e_ready);
    check("iss_hazard", s_haz, haz);
    check("pending", s_pend, e_pend);
    check("rf_write", s_rfw, m_wr && !rst);
    check("rf_rd", s_rd, m_rd);
    check("rf_wdata", s_wdata, m_wdata);

    if (rst) begin
      m_wr = 1'b0; m_rd = '0; m_wdata = '0; m_last = N - 1;
      for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
    end else begin
      if (m_wr) begin
        m_rf[m_rd]   = m_wdata;
        m_pend[m_rd] = 1'b0;
      end
      if (iss_valid && !haz && iss_rd != AW'(ZR)) m_pend[iss_rd] = 1'b1;
      if (g >= 0) begin
        m_wr    = (req_rd[g] != AW'(ZR));
        m_rd    = req_rd[g];
        m_wdata = req_data[g];
        m_last  = g;
        req_v[g] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2);
    iss_valid = v; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_g;
    logic [DW-1:0] old9;
    for (int r = 0; r < NR; r++) begin
      dut_rf[r] = '0; m_rf[r] = '0; m_pend[r] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; req_rd[i] = '0; req_data[i] = '0;
    end
    m_wr = 1'b0; m_rd = '0; m_wdata = '0; m_last = N - 1;
    wb_valid = '0; wb_rd = '0; wb_data = '0;
    issue(1'b0, '0, '0, '0);

    // Reset, with a request held to confirm no grant while rst is high
    rst = 1'b1;
    step();
    req_v[1] = 1'b1; req_rd[1] = 4'd2; req_data[1] = 32'h1234;
    step();
    check("rst_ready", s_ready, 3'b000);
    req_v[1] = 1'b0;
    rst = 1'b0;

    // Single write: requester 0, R3 <= DEADBEEF
    req_v[0] = 1'b1; req_rd[0] = 4'd3; req_data[0] = 32'hDEADBEEF;
    step();
    check("A_ready", s_ready, 3'b001);
    step();
    check("A_rfw", s_rfw, 1'b1);
    check("A_rd", s_rd, 4'd3);
    check("A_wdata", s_wdata, 32'hDEADBEEF);
    check("A_R3", dut_rf[3], 32'hDEADBEEF);

    // All requesters continuously valid for six cycles, fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        req_v[i] = 1'b1; req_rd[i] = AW'(i + 1); req_data[i] = $urandom;
      end
      step();
`ifdef WB_RR_ARB_EN
      exp_g = 3'b001 << (c % 3);
`else
      exp_g = 3'b001;
`endif
      check("B_order", s_ready, exp_g);
    end
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    step();

    // Write to the hardwired-zero register is accepted then discarded
    req_v[1] = 1'b1; req_rd[1] = 4'(ZR); req_data[1] = 32'd5;
    step();
    check("C_ready", s_ready, 3'b010);
    step();
    check("C_rfw", s_rfw, 1'b0);
    check("C_pend14", s_pend[ZR], 1'b0);

    // Scoreboard claim, hazard, and clear by writeback
    issue(1'b1, 4'd7, 4'd0, 4'd1);
    step();
    issue(1'b1, 4'd8, 4'd7, 4'd0);
    step();
    check("D_haz", s_haz, 1'b1);
    check("D_pend7", s_pend[7], 1'b1);
    issue(1'b0, '0, '0, '0);
    step();
    check("D_noset8", s_pend[8], 1'b0);
    req_v[2] = 1'b1; req_rd[2] = 4'd7; req_data[2] = 32'h77;
    step();
    step();
    check("D_pend7_n1", s_pend[7], 1'b1);
    step();
    check("D_pend7_n2", s_pend[7], 1'b0);

    // Claim the same register that is retiring this cycle: claim wins
    req_v[0] = 1'b1; req_rd[0] = 4'd5; req_data[0] = 32'h55;
    step();
    issue(1'b1, 4'd5, 4'd0, 4'd0);
    step();
    check("E_rfw", s_rfw, 1'b1);
    check("E_rd", s_rd, 4'd5);
    issue(1'b0, '0, '0, '0);
    step();
    check("E_pend5", s_pend[5], 1'b1);

    // Reset right after a transfer drops the in-flight write
    old9 = dut_rf[9];
    req_v[0] = 1'b1; req_rd[0] = 4'd9; req_data[0] = 32'h99999999;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("F_rfw", s_rfw, 1'b0);
    check("F_pend", s_pend, 16'h0);
    check("F_R9", dut_rf[9], old9);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 1) == 1) begin
          req_v[i] = 1'b1;
          req_rd[i] = ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, NR - 1));
          req_data[i] = $urandom;
        end
      end
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
      step();
    end
    rst = 1'b0;
    issue(1'b0, '0, '0, '0);
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    step();
    step();
    for (int r = 0; r < NR; r++) check($sformatf("rf_R%0d", r), dut_rf[r], m_rf[r]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
